// File: rtl/inst_ram_loader.sv
// inst_ram_loader
// Writable 32 x 32 instruction memory for the single-cycle MIPS datapath.
// A program arrives as a valid/ready stream of instruction words and is
// written from word 0 upward. Any words the program does not reach are
// zero-filled so they read as nop. The CPU is held while the memory is
// being cleared or loaded. Fetch reads are combinational: inst = mem[pc].
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   load_start : one-cycle request to begin a load (honoured only in IDLE)
//   ld_data    : instruction word of the current beat
//   ld_valid   : ld_data / ld_last are valid
//   ld_last    : marks the final word of the program
//   ld_ready   : loader accepts a word this cycle (LOAD state only)
//   pc         : fetch word address
//   inst       : fetched instruction, forced to nop while cpu_hold is high
//   cpu_hold   : CPU must not advance pc or commit state
//   load_done  : one-cycle pulse when a load has finished and memory is valid
//   load_count : words accepted in the current or last load (0..DEPTH)
//   err_trunc  : sticky, DEPTH words were accepted without ld_last
module inst_ram_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] inst,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              err_trunc
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] wr_ptr_d;
  logic              loading;
  logic              loading_d;
  logic [ADDR_W:0]   count_d;
  logic              err_d;
  logic              done_d;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              beat;
  logic              at_end;

  logic [DATA_W-1:0] mem [DEPTH];

  // Handshake outputs come straight from the state register, so there is
  // no combinational path from ld_valid to ld_ready.
  assign ld_ready = (state == LOAD);
  assign cpu_hold = (state != IDLE);
  assign beat     = ld_valid & ld_ready;
  assign at_end   = (wr_ptr == LAST_ADDR);

  always_comb begin
    state_d   = state;
    wr_ptr_d  = wr_ptr;
    loading_d = loading;
    count_d   = load_count;
    err_d     = err_trunc;
    done_d    = 1'b0;
    we        = 1'b0;
    wdata     = '0;
    case (state)
      FILL: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr + 1'b1;
        if (at_end) begin
          state_d   = IDLE;
          wr_ptr_d  = '0;
          // Only a fill that finishes a load reports completion; the
          // power-on / post-reset clear does not.
          done_d    = loading;
          loading_d = 1'b0;
        end
      end
      IDLE: begin
        if (load_start) begin
          state_d   = LOAD;
          wr_ptr_d  = '0;
          count_d   = '0;
          err_d     = 1'b0;
          loading_d = 1'b1;
        end
      end
      LOAD: begin
        if (beat) begin
          we       = 1'b1;
          wdata    = ld_data;
          wr_ptr_d = wr_ptr + 1'b1;
          count_d  = load_count + 1'b1;
          if (at_end) begin
            // Memory is full: nothing left to fill, finish directly.
            state_d   = IDLE;
            wr_ptr_d  = '0;
            done_d    = 1'b1;
            loading_d = 1'b0;
            err_d     = err_trunc | ~ld_last;
          end else if (ld_last) begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      loading    <= 1'b0;
      load_count <= '0;
      err_trunc  <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_d;
      loading    <= loading_d;
      load_count <= count_d;
      err_trunc  <= err_d;
      load_done  <= done_d;
    end
  end

  // RAM contents carry no reset; the FILL state clears them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign inst = cpu_hold ? '0 : mem[pc];

endmodule

// File: tb/tb_inst_ram_loader.sv
`timescale 1ns/1ps
module tb_inst_ram_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        ld_last;
  logic        ld_ready;
  logic [4:0]  pc;
  logic [31:0] inst;
  logic        cpu_hold;
  logic        load_done;
  logic [5:0]  load_count;
  logic        err_trunc;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb [$];
  logic [31:0] prog [32];

  inst_ram_loader #(.DEPTH(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .ld_data    (ld_data),
    .ld_valid   (ld_valid),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .pc         (pc),
    .inst       (inst),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_count (load_count),
    .err_trunc  (err_trunc)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one load: start pulse, beats from prog[] following the valid
  // pattern, then waits (bounded) for load_done. Every driven beat is pushed
  // to the scoreboard. lat = edges from the start edge until load_done is
  // visible, or -1 on timeout.
  task automatic drive_load(input int n, input logic use_last, input logic [63:0] vpat,
                            input logic chain, output int lat, output int ready_bad,
                            output int hold_bad, output logic ready_done,
                            output logic hold_done, output logic done_stuck);
    int b;
    int c;
    b = 0;
    c = 0;
    lat = -1;
    ready_bad = 0;
    hold_bad = 0;
    done_stuck = 1'b0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    while (b < n && c < 64) begin
      if (vpat[c]) begin
        ld_valid = 1'b1;
        ld_data  = prog[b];
        ld_last  = use_last && (b == n - 1);
        sb.push_back(prog[b]);
        b++;
      end else begin
        ld_valid = 1'b0;
        ld_data  = 32'hDEADBEEF;
        ld_last  = 1'b1;
      end
      if (ld_ready !== 1'b1) ready_bad++;
      if (cpu_hold !== 1'b1 || inst !== 32'h0) hold_bad++;
      step();
      c++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = '0;
    while (load_done !== 1'b1 && c < 100) begin
      if (ld_ready !== 1'b0) ready_bad++;
      if (cpu_hold !== 1'b1 || inst !== 32'h0) hold_bad++;
      step();
      c++;
    end
    if (load_done === 1'b1) lat = c;
    ready_done = ld_ready;
    hold_done  = cpu_hold;
    if (!chain) begin
      step();
      done_stuck = (load_done !== 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pc = 5'h03;
    step();
    step();
    checks++;
    if (cpu_hold !== 1'b1 || ld_ready !== 1'b0 || load_done !== 1'b0 ||
        load_count !== 6'd0 || err_trunc !== 1'b0 || inst !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: hold=%b ready=%b done=%b count=%0d err=%b inst=%h, expected 1 0 0 0 0 00000000",
               cpu_hold, ld_ready, load_done, load_count, err_trunc, inst);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (cpu_hold !== 1'b1 || inst !== 32'h0 || load_done !== 1'b0) begin
        errors++;
        $display("FAIL poweron_fill[%0d]: hold=%b inst=%h done=%b, expected hold=1 inst=0 done=0",
                 i, cpu_hold, inst, load_done);
      end
      step();
    end
    checks++;
    if (cpu_hold !== 1'b0 || inst !== 32'h0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL poweron_idle: hold=%b inst=%h done=%b, expected hold=0 inst=0 done=0",
               cpu_hold, inst, load_done);
    end
    for (int a = 0; a < 32; a++) begin
      pc = 5'(a);
      #1;
      checks++;
      if (inst !== 32'h0) begin
        errors++;
        $display("FAIL poweron_mem[%0d]: got %h expected 00000000", a, inst);
      end
    end
    pc = 5'h03;
    step();
    checks++;
    if (load_done !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL poweron_no_done: done=%b hold=%b, expected 0 0", load_done, cpu_hold);
    end
  endtask

  task automatic test_short_load();
    int lat, rb, hb;
    logic rd, hd, st;
    logic [31:0] exp_w;
    sb.delete();
    prog[0] = 32'h00430820;
    prog[1] = 32'h00641022;
    prog[2] = 32'h34a60008;
    pc = 5'h01;
    drive_load(3, 1'b1, '1, 1'b0, lat, rb, hb, rd, hd, st);
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("FAIL short_latency: load_done after %0d edges, expected 32", lat);
    end
    checks++;
    if (rb !== 0 || rd !== 1'b0) begin
      errors++;
      $display("FAIL short_ready: %0d bad cycles, ready at done=%b, expected 0 and 0", rb, rd);
    end
    checks++;
    if (hb !== 0 || hd !== 1'b0 || st !== 1'b0) begin
      errors++;
      $display("FAIL short_hold: bad=%0d hold_at_done=%b done_stuck=%b, expected 0 0 0", hb, hd, st);
    end
    checks++;
    if (load_count !== 6'd3 || err_trunc !== 1'b0) begin
      errors++;
      $display("FAIL short_count: count=%0d err=%b, expected 3 0", load_count, err_trunc);
    end
    for (int a = 0; a < 32; a++) begin
      pc = 5'(a);
      #1;
      exp_w = (sb.size() != 0) ? sb.pop_front() : 32'h0;
      checks++;
      if (inst !== exp_w) begin
        errors++;
        $display("FAIL short_mem[%0d]: got %h expected %h", a, inst, exp_w);
      end
    end
    pc = 5'h01;
    #1;
    checks++;
    if (inst !== 32'h00641022) begin
      errors++;
      $display("FAIL short_pc1: got %h expected 00641022", inst);
    end
    pc = 5'h1F;
    #1;
    checks++;
    if (inst !== 32'h0) begin
      errors++;
      $display("FAIL short_pc31: got %h expected 00000000", inst);
    end
    pc = 5'h01;
  endtask

  task automatic test_stalled_stream();
    int lat, rb, hb;
    logic rd, hd, st;
    logic [31:0] exp_w;
    sb.delete();
    prog[0] = 32'h20010005;
    prog[1] = 32'h20020007;
    prog[2] = 32'h00221820;
    drive_load(3, 1'b1, 64'b11001, 1'b0, lat, rb, hb, rd, hd, st);
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL stall_latency: load_done after %0d edges, expected 34", lat);
    end
    checks++;
    if (rb !== 0 || hb !== 0 || st !== 1'b0) begin
      errors++;
      $display("FAIL stall_ctrl: ready_bad=%0d hold_bad=%0d done_stuck=%b, expected 0 0 0", rb, hb, st);
    end
    checks++;
    if (load_count !== 6'd3) begin
      errors++;
      $display("FAIL stall_count: got %0d expected 3", load_count);
    end
    for (int a = 0; a < 32; a++) begin
      pc = 5'(a);
      #1;
      exp_w = (sb.size() != 0) ? sb.pop_front() : 32'h0;
      checks++;
      if (inst !== exp_w) begin
        errors++;
        $display("FAIL stall_mem[%0d]: got %h expected %h", a, inst, exp_w);
      end
    end
    pc = 5'h01;
  endtask

  // Leaves the bench in the load_done cycle so the next load starts back-to-back.
  task automatic test_full_truncated();
    int lat, rb, hb;
    logic rd, hd, st;
    logic [31:0] exp_w;
    sb.delete();
    for (int i = 0; i < 32; i++) prog[i] = 32'hA5000000 + 32'(i);
    drive_load(32, 1'b0, '1, 1'b1, lat, rb, hb, rd, hd, st);
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("FAIL full_latency: load_done after %0d edges, expected 32", lat);
    end
    checks++;
    if (rb !== 0 || rd !== 1'b0 || hb !== 0 || hd !== 1'b0) begin
      errors++;
      $display("FAIL full_ctrl: ready_bad=%0d ready_at_done=%b hold_bad=%0d hold_at_done=%b, expected 0 0 0 0",
               rb, rd, hb, hd);
    end
    checks++;
    if (err_trunc !== 1'b1 || load_count !== 6'd32) begin
      errors++;
      $display("FAIL full_trunc: err=%b count=%0d, expected 1 32", err_trunc, load_count);
    end
    for (int a = 0; a < 32; a++) begin
      pc = 5'(a);
      #1;
      exp_w = (sb.size() != 0) ? sb.pop_front() : 32'h0;
      checks++;
      if (inst !== exp_w) begin
        errors++;
        $display("FAIL full_mem[%0d]: got %h expected %h", a, inst, exp_w);
      end
    end
    pc = 5'h1F;
    #1;
    checks++;
    if (inst !== 32'hA500001F) begin
      errors++;
      $display("FAIL full_pc31: got %h expected a500001f", inst);
    end
    pc = 5'h02;
  endtask

  task automatic test_back_to_back();
    int lat, rb, hb;
    logic rd, hd, st;
    logic [31:0] exp_w;
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_entry: load_done=%b expected 1", load_done);
    end
    sb.delete();
    prog[0] = 32'h11111111;
    prog[1] = 32'h22222222;
    drive_load(2, 1'b1, '1, 1'b0, lat, rb, hb, rd, hd, st);
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("FAIL b2b_latency: load_done after %0d edges, expected 32", lat);
    end
    checks++;
    if (rb !== 0 || hb !== 0 || st !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ctrl: ready_bad=%0d hold_bad=%0d done_stuck=%b, expected 0 0 0", rb, hb, st);
    end
    checks++;
    if (err_trunc !== 1'b0 || load_count !== 6'd2) begin
      errors++;
      $display("FAIL b2b_status: err=%b count=%0d, expected 0 2", err_trunc, load_count);
    end
    for (int a = 0; a < 32; a++) begin
      pc = 5'(a);
      #1;
      exp_w = (sb.size() != 0) ? sb.pop_front() : 32'h0;
      checks++;
      if (inst !== exp_w) begin
        errors++;
        $display("FAIL reload_mem[%0d]: got %h expected %h", a, inst, exp_w);
      end
    end
    pc = 5'h01;
  endtask

  task automatic test_reset_midload();
    sb.delete();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      ld_valid = 1'b1;
      ld_data  = 32'hC0DE0000 + 32'(b);
      ld_last  = 1'b0;
      step();
    end
    ld_valid = 1'b0;
    ld_data  = '0;
    checks++;
    if (load_count !== 6'd4 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL midload_pre: count=%0d hold=%b, expected 4 1", load_count, cpu_hold);
    end
    rst_n = 1'b0;
    #5;
    checks++;
    if (cpu_hold !== 1'b1 || ld_ready !== 1'b0 || load_count !== 6'd0 ||
        load_done !== 1'b0 || inst !== 32'h0) begin
      errors++;
      $display("FAIL midload_reset: hold=%b ready=%b count=%0d done=%b inst=%h, expected 1 0 0 0 00000000",
               cpu_hold, ld_ready, load_count, load_done, inst);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      load_start = (i == 5);
      checks++;
      if (ld_ready !== 1'b0 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
        errors++;
        $display("FAIL midload_fill[%0d]: ready=%b hold=%b done=%b, expected 0 1 0",
                 i, ld_ready, cpu_hold, load_done);
      end
      step();
    end
    load_start = 1'b0;
    checks++;
    if (cpu_hold !== 1'b0 || load_done !== 1'b0 || ld_ready !== 1'b0 || load_count !== 6'd0) begin
      errors++;
      $display("FAIL midload_idle: hold=%b done=%b ready=%b count=%0d, expected 0 0 0 0",
               cpu_hold, load_done, ld_ready, load_count);
    end
    for (int a = 0; a < 32; a++) begin
      pc = 5'(a);
      #1;
      checks++;
      if (inst !== 32'h0) begin
        errors++;
        $display("FAIL midload_mem[%0d]: got %h expected 00000000", a, inst);
      end
    end
    step();
    checks++;
    if (ld_ready !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start: ready=%b hold=%b, expected 0 0", ld_ready, cpu_hold);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    ld_valid   = 1'b0;
    ld_last    = 1'b0;
    ld_data    = '0;
    pc         = 5'h03;
    test_reset();
    test_short_load();
    test_stalled_stream();
    test_full_truncated();
    test_back_to_back();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
